// File: rtl/rfa_serial_adder_if.sv
// Operand/result bundle for rfa_serial_adder; ovf exists only when RFA_SERIAL_OVF_EN is defined.
interface rfa_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             gp;
  logic             gg;
`ifdef RFA_SERIAL_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
`ifdef RFA_SERIAL_OVF_EN
    input  ovf,
`endif
    input  busy, done, sum, cout, gp, gg
  );

  modport slave (
    input  start, a, b, cin,
`ifdef RFA_SERIAL_OVF_EN
    output ovf,
`endif
    output busy, done, sum, cout, gp, gg
  );
endinterface

// File: rtl/rfa_serial_adder.sv
// Bit-serial adder that reuses one RFA slice LSB-first with a registered ripple carry and group P/G.
// Optional signed-overflow output is enabled by defining RFA_SERIAL_OVF_EN.
module rfa_serial_adder #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  rfa_serial_adder_if.slave bus
);
  localparam int            IW       = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reduced full adder slice: returns {g, p, s}.
  function automatic logic [2:0] rfa_cell(input logic ai, input logic bi, input logic ci);
    logic p;
    logic g;
    p = ai ^ bi;
    g = ai & bi;
    return {g, p, p ^ ci};
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, a_s, b_r, b_s;
  logic             carry_r, carry_s, carry_nx_s;
  logic [IW-1:0]    idx_r, idx_s;
  logic             gp_acc_r, gp_acc_s, gg_acc_r, gg_acc_s;
  logic [WIDTH-1:0] sum_sh_r, sum_sh_s;
  logic [WIDTH-1:0] sum_r, sum_s;
  logic             cout_r, cout_s, gp_r, gp_s, gg_r, gg_s;
  logic             busy_r, done_r;
  logic [2:0]       cell_s;
`ifdef RFA_SERIAL_OVF_EN
  logic             ovf_r, ovf_s;
`endif

  // Next-state and datapath update for the serial sequencer.
  always_comb begin
    cell_s     = rfa_cell(a_r[idx_r], b_r[idx_r], carry_r);
    carry_nx_s = cell_s[2] | (cell_s[1] & carry_r);
    state_s    = state_r;
    a_s        = a_r;
    b_s        = b_r;
    carry_s    = carry_r;
    idx_s      = idx_r;
    gp_acc_s   = gp_acc_r;
    gg_acc_s   = gg_acc_r;
    sum_sh_s   = sum_sh_r;
    sum_s      = sum_r;
    cout_s     = cout_r;
    gp_s       = gp_r;
    gg_s       = gg_r;
`ifdef RFA_SERIAL_OVF_EN
    ovf_s      = ovf_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          a_s      = bus.a;
          b_s      = bus.b;
          carry_s  = bus.cin;
          idx_s    = {IW{1'b0}};
          gp_acc_s = 1'b1;
          gg_acc_s = 1'b0;
          state_s  = ST_RUN;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_sh_s[idx_r] = cell_s[0];
        carry_s         = carry_nx_s;
        gp_acc_s        = gp_acc_r & cell_s[1];
        gg_acc_s        = cell_s[2] | (cell_s[1] & gg_acc_r);
        // idx holds on the last bit so it never wraps.
        if (idx_r == LAST_IDX) begin
          state_s = ST_DONE;
          sum_s   = sum_sh_s;
          cout_s  = carry_nx_s;
          gp_s    = gp_acc_s;
          gg_s    = gg_acc_s;
`ifdef RFA_SERIAL_OVF_EN
          ovf_s   = carry_r ^ carry_nx_s;
`endif
        end else begin
          idx_s   = idx_r + IW'(1);
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State and result registers; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      idx_r    <= {IW{1'b0}};
      gp_acc_r <= 1'b0;
      gg_acc_r <= 1'b0;
      sum_sh_r <= {WIDTH{1'b0}};
      sum_r    <= {WIDTH{1'b0}};
      cout_r   <= 1'b0;
      gp_r     <= 1'b0;
      gg_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef RFA_SERIAL_OVF_EN
      ovf_r    <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      a_r      <= a_s;
      b_r      <= b_s;
      carry_r  <= carry_s;
      idx_r    <= idx_s;
      gp_acc_r <= gp_acc_s;
      gg_acc_r <= gg_acc_s;
      sum_sh_r <= sum_sh_s;
      sum_r    <= sum_s;
      cout_r   <= cout_s;
      gp_r     <= gp_s;
      gg_r     <= gg_s;
      busy_r   <= (state_s == ST_RUN);
      done_r   <= (state_s == ST_DONE);
`ifdef RFA_SERIAL_OVF_EN
      ovf_r    <= ovf_s;
`endif
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.gp   = gp_r;
  assign bus.gg   = gg_r;
`ifdef RFA_SERIAL_OVF_EN
  assign bus.ovf  = ovf_r;
`endif
endmodule

// File: tb/tb_rfa_serial_adder.sv
// Self-checking bench for rfa_serial_adder: directed and random operand pairs against an arithmetic model.
module tb_rfa_serial_adder;
  localparam int W = 8;

  logic         clk;
  logic         reset;
  int           vectors;
  int           miscompares;
  logic [W-1:0] exp_sum;
  logic         exp_cout, exp_gp, exp_gg, exp_ovf;

  rfa_serial_adder_if #(.WIDTH(W)) bus();
  rfa_serial_adder #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_results(input string tag);
    chk({tag, ".sum"},  32'(bus.sum),  32'(exp_sum));
    chk({tag, ".cout"}, 32'(bus.cout), 32'(exp_cout));
    chk({tag, ".gp"},   32'(bus.gp),   32'(exp_gp));
    chk({tag, ".gg"},   32'(bus.gg),   32'(exp_gg));
`ifdef RFA_SERIAL_OVF_EN
    chk({tag, ".ovf"},  32'(bus.ovf),  32'(exp_ovf));
`endif
  endtask

  // Reference: plain integer addition plus whole-word propagate/generate definitions.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] total;
    logic [W:0] nocarry;
    total    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    nocarry  = {1'b0, a} + {1'b0, b};
    exp_sum  = total[W-1:0];
    exp_cout = total[W];
    exp_gp   = &(a ^ b);
    exp_gg   = nocarry[W];
    exp_ovf  = (a[W-1] == b[W-1]) && (total[W-1] != a[W-1]);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input bit repulse);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    for (int cyc = 1; cyc <= W + 1; cyc++) begin
      @(negedge clk);
      if (cyc <= W) begin
        chk($sformatf("run%0d.busy_done", cyc), 32'({bus.busy, bus.done}), 32'(2'b10));
        chk_results("hold");
      end else begin
        chk("done.busy_done", 32'({bus.busy, bus.done}), 32'(2'b01));
        model(a, b, cin);
        chk_results("result");
      end
      bus.start = repulse && (cyc == 3 || cyc == W + 1);
      if (repulse) begin
        bus.a   = 8'hAA;
        bus.b   = 8'h55;
        bus.cin = 1'b1;
      end else begin
        bus.a   = W'($urandom);
        bus.b   = W'($urandom);
      end
    end
    @(negedge clk);
    chk("post.busy_done", 32'({bus.busy, bus.done}), 32'(2'b00));
    chk_results("post");
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_sum  = {W{1'b0}};
    exp_cout = 1'b0;
    exp_gp   = 1'b0;
    exp_gg   = 1'b0;
    exp_ovf  = 1'b0;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.cin   = 1'b1;

    // Reset held two cycles with start asserted: reset must win.
    @(negedge clk);
    @(negedge clk);
    chk("reset.busy_done", 32'({bus.busy, bus.done}), 32'(2'b00));
    chk_results("reset");
    bus.start = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    chk("idle.busy_done", 32'({bus.busy, bus.done}), 32'(2'b00));

    run_op(8'h0F, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'h00, 1'b1, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(8'h03, 8'h04, 1'b0, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0);

    // Reset during the 4th RUN cycle abandons the operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hF0;
    bus.b     = 8'h0F;
    bus.cin   = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk("abort.busy", 32'(bus.busy), 32'(1'b1));
    end
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    exp_sum  = {W{1'b0}};
    exp_cout = 1'b0;
    exp_gp   = 1'b0;
    exp_gg   = 1'b0;
    exp_ovf  = 1'b0;
    chk("abort.busy_done", 32'({bus.busy, bus.done}), 32'(2'b00));
    chk_results("abort");
    for (int cyc = 0; cyc < W + 2; cyc++) begin
      @(negedge clk);
      chk("abort.no_done", 32'({bus.busy, bus.done}), 32'(2'b00));
    end
    run_op(8'h01, 8'h01, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(1, 0)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
